uart_tx_lite: RTL and testbench

Memory-mapped UART transmitter with an internal byte FIFO. It is a slave on the data-memory port of the `bitty_riscv` core and consumes that port's bus requests (ce/we/sel/addr/data) in the MEM stage. The system bus decoder qualifies `ce_i` for this block's address window. It serialises queued bytes as 8N1 frames on `tx_o` and raises an optional interrupt when transmission drains.

---
 rtl/uart_tx_lite.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_lite.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_lite.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, baud divisor and
// drain interrupt; register reads are combinational for same-cycle sampling.
module uart_tx_lite #(
    parameter int                   FIFO_DEPTH  = 8,
    parameter int                   DIV_WIDTH   = 16,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 ovf;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_mask;
    logic [DIV_WIDTH-1:0] div_next;
    logic                 tx_en;
    logic                 irq_en;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift;
    logic                 tx_q;

    logic       wr;
    logic       push;
    logic       push_ok;
    logic       pop;
    logic       full;
    logic       empty;
    logic       baud_zero;
    logic [1:0] reg_sel;
    logic       unused_bits;

    assign reg_sel     = addr_i[3:2];
    assign wr          = ce_i & we_i;
    assign push        = wr & (reg_sel == 2'd0) & sel_i[0];
    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign push_ok     = push & ~full;
    assign baud_zero   = (baud_cnt == '0);
    // A pop happens from IDLE or straight out of the last STOP clock.
    assign pop         = tx_en & ~empty & ((state == IDLE) | ((state == STOP) & baud_zero));
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i, sel_i};

    for (genvar i = 0; i < DIV_WIDTH; i++) begin : g_div_mask
        assign div_mask[i] = sel_i[i / 8];
    end
    assign div_next = (div_q & ~div_mask) | (data_i[DIV_WIDTH-1:0] & div_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= DEFAULT_DIV;
            tx_en  <= 1'b0;
            irq_en <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (wr && reg_sel == 2'd2) begin
                div_q <= div_next;
            end
            if (wr && reg_sel == 2'd3 && sel_i[0]) begin
                tx_en  <= data_i[0];
                irq_en <= data_i[1];
            end
            if (push && full) begin
                ovf <= 1'b1;
            end else if (wr && reg_sel == 2'd1 && sel_i[0] && data_i[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // tx_q is set on each transition so the line level is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= div_q;
                        bit_cnt  <= '0;
                        tx_q     <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_zero) begin
                        baud_cnt <= div_q;
                        bit_cnt  <= '0;
                        tx_q     <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (baud_zero) begin
                        baud_cnt <= div_q;
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - DIV_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (baud_zero) begin
                        if (pop) begin
                            shift    <= mem[rd_ptr];
                            baud_cnt <= div_q;
                            bit_cnt  <= '0;
                            tx_q     <= 1'b0;
                            state    <= START;
                        end else begin
                            tx_q  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - DIV_WIDTH'(1);
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_o = '0;
        if (ce_i && !we_i) begin
            case (reg_sel)
                2'd1: begin
                    data_o[0]       = (state != IDLE);
                    data_o[1]       = full;
                    data_o[2]       = empty;
                    data_o[3]       = ovf;
                    data_o[8 +: CW] = count;
                end
                2'd2:    data_o[DIV_WIDTH-1:0] = div_q;
                2'd3:    data_o[1:0]           = {irq_en, tx_en};
                default: data_o                = '0;
            endcase
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_en & empty & (state == IDLE);

endmodule

// File: tb/tb_uart_tx_lite.sv
// Randomised bench for uart_tx_lite: a queue-based FIFO model plus an ideal
// 8N1 frame model predict every line sample and every STATUS readback.
module tb_uart_tx_lite;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_o;
    logic        irq_o;

    int          n_checks = 0;
    int          n_errors = 0;
    byte unsigned model_q[$];
    bit          model_ovf = 1'b0;
    int          busy_cnt;
    int          irq_cnt;
    int          last_wait;

    always #5 clk = ~clk;

    uart_tx_lite dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .tx_o   (tx_o),
        .irq_o  (irq_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
        addr_i = {28'd0, r, 2'b00};
        data_i = d;
        sel_i  = s;
        ce_i   = 1'b1;
        we_i   = 1'b1;
        tick();
        ce_i   = 1'b0;
        we_i   = 1'b0;
        data_i = '0;
        sel_i  = '0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        addr_i = {28'd0, r, 2'b00};
        ce_i   = 1'b1;
        we_i   = 1'b0;
        #1;
        d      = data_o;
        ce_i   = 1'b0;
        addr_i = '0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        if (model_q.size() >= DEPTH) model_ovf = 1'b1;
        else model_q.push_back(b);
        bus_write(2'd0, {24'd0, b}, 4'h1);
    endtask

    // inflight: bytes already popped by the transmitter but still in model_q
    function automatic logic [31:0] exp_status(input bit busy, input int inflight);
        int          cnt;
        logic [31:0] s;
        cnt     = model_q.size() - inflight;
        s       = '0;
        s[12:8] = cnt[4:0];
        s[3]    = model_ovf;
        s[2]    = (cnt == 0);
        s[1]    = (cnt == DEPTH);
        s[0]    = busy;
        return s;
    endfunction

    // Samples n contiguous frames; each bit slot must be constant for div+1 clocks.
    task automatic rx_frames(input int n, input int div, input string tag);
        int           waited;
        byte unsigned b;
        logic [31:0]  obs;
        logic [31:0]  exp;
        logic [31:0]  mask;
        logic [31:0]  st;
        bit           expb;
        waited   = 0;
        busy_cnt = 0;
        irq_cnt  = 0;
        while (tx_o !== 1'b0 && waited < 40) begin
            tick();
            waited++;
        end
        last_wait = waited;
        if (tx_o !== 1'b0) begin
            check_val($sformatf("%s_start_timeout", tag), {31'd0, tx_o}, 32'd0);
            return;
        end
        mask = (32'd1 << (div + 1)) - 32'd1;
        for (int f = 0; f < n; f++) begin
            b = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
            for (int s = 0; s < 10; s++) begin
                if (s == 0) expb = 1'b0;
                else if (s == 9) expb = 1'b1;
                else expb = b[s-1];
                exp = expb ? mask : 32'd0;
                obs = '0;
                for (int c = 0; c <= div; c++) begin
                    obs[c] = tx_o;
                    bus_read(2'd1, st);
                    busy_cnt += int'(st[0]);
                    irq_cnt  += int'(irq_o);
                    tick();
                end
                check_val($sformatf("%s_f%0d_slot%0d", tag, f, s), obs, exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int          w;
        int          low_cnt;
        int          dv;
        int          n;

        rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0; sel_i = '0;
        repeat (3) tick();
        rst = 1'b0;

        check_val("rst_tx", {31'd0, tx_o}, 32'd1);
        check_val("rst_irq", {31'd0, irq_o}, 32'd0);
        check_val("rst_data_idle", data_o, 32'd0);
        bus_read(2'd1, d); check_val("rst_status", d, 32'h4);
        bus_read(2'd2, d); check_val("rst_div", d, 32'd433);
        bus_read(2'd3, d); check_val("rst_ctrl", d, 32'd0);
        addr_i = 32'h4; ce_i = 1'b1; we_i = 1'b1; sel_i = 4'h0; #1;
        check_val("data_on_write", data_o, 32'd0);
        ce_i = 1'b0; we_i = 1'b0; addr_i = '0;

        // Single frame, DIV=3
        bus_write(2'd2, 32'd3, 4'hF);
        bus_write(2'd3, 32'd1, 4'h1);
        push_byte(8'h55);
        rx_frames(1, 3, "single");
        check_val("single_latency", last_wait, 32'd1);
        check_val("single_busy_clocks", busy_cnt, 32'd40);
        bus_read(2'd1, d); check_val("single_status_after", d, exp_status(1'b0, 0));
        check_val("single_tx_idle", {31'd0, tx_o}, 32'd1);

        // Overflow and wrap, then a burst of back-to-back frames
        bus_write(2'd3, 32'd0, 4'h1);
        bus_write(2'd2, 32'd1, 4'h3);
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        bus_read(2'd1, d); check_val("ovf_status", d, exp_status(1'b0, 0));
        bus_write(2'd3, 32'd1, 4'h1);
        rx_frames(8, 1, "burst");
        check_val("burst_latency", last_wait, 32'd1);
        check_val("burst_busy_clocks", busy_cnt, 32'd160);
        bus_read(2'd1, d); check_val("burst_status_after", d, exp_status(1'b0, 0));
        bus_write(2'd1, 32'h8, 4'h1);
        model_ovf = 1'b0;
        bus_read(2'd1, d); check_val("ovf_clear", d, exp_status(1'b0, 0));

        // Interrupt with DIV=0
        bus_write(2'd2, 32'd0, 4'hF);
        bus_write(2'd3, 32'd3, 4'h1);
        check_val("irq_idle_empty", {31'd0, irq_o}, 32'd1);
        push_byte(8'hA5);
        check_val("irq_after_push", {31'd0, irq_o}, 32'd0);
        rx_frames(1, 0, "irq");
        check_val("irq_low_in_frame", irq_cnt, 32'd0);
        check_val("irq_rise", {31'd0, irq_o}, 32'd1);

        // Byte enables and push/pop on the same edge
        bus_write(2'd3, 32'd0, 4'h1);
        bus_write(2'd0, 32'h77, 4'b1110);
        bus_read(2'd1, d); check_val("sel_no_push", d, exp_status(1'b0, 0));
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
        bus_write(2'd3, 32'd1, 4'h1);
        push_byte(8'($urandom_range(0, 255)));
        bus_read(2'd1, d); check_val("simul_cnt4", d, exp_status(1'b1, 1));
        rx_frames(5, 0, "simul4");
        bus_write(2'd3, 32'd0, 4'h1);
        for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
        bus_write(2'd3, 32'd1, 4'h1);
        push_byte(8'hEE);
        bus_read(2'd1, d); check_val("simul_cnt8", d, exp_status(1'b1, 1));
        rx_frames(8, 0, "simul8");
        bus_write(2'd1, 32'h8, 4'h1);
        model_ovf = 1'b0;

        // Reset during data bit 3
        bus_write(2'd3, 32'd0, 4'h1);
        bus_write(2'd2, 32'd3, 4'h3);
        push_byte(8'hC3);
        push_byte(8'h3C);
        bus_write(2'd3, 32'd1, 4'h1);
        w = 0;
        while (tx_o !== 1'b0 && w < 40) begin
            tick();
            w++;
        end
        check_val("rstmid_start", {31'd0, tx_o}, 32'd0);
        repeat (17) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        check_val("rstmid_tx", {31'd0, tx_o}, 32'd1);
        bus_read(2'd1, d); check_val("rstmid_status", d, 32'h4);
        bus_write(2'd2, 32'd0, 4'hF);
        bus_write(2'd3, 32'd1, 4'h1);
        low_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx_o !== 1'b1) low_cnt++;
            tick();
        end
        check_val("rstmid_no_frames", low_cnt, 32'd0);

        // Random bursts
        for (int it = 0; it < 6; it++) begin
            dv = $urandom_range(0, 3);
            n  = $urandom_range(1, DEPTH);
            bus_write(2'd3, 32'd0, 4'h1);
            bus_write(2'd2, dv, 4'hF);
            for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
            bus_read(2'd1, d); check_val($sformatf("rnd%0d_status", it), d, exp_status(1'b0, 0));
            bus_write(2'd3, 32'd1, 4'h1);
            rx_frames(n, dv, $sformatf("rnd%0d", it));
            check_val($sformatf("rnd%0d_busy", it), busy_cnt, 10 * (dv + 1) * n);
            bus_read(2'd1, d); check_val($sformatf("rnd%0d_drained", it), d, exp_status(1'b0, 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
